// File: rtl/bsg_manycore_store_ack_tracker.sv
// Outstanding remote-store counter plus a small queue of outgoing store-acks.
// The proc fences on stores_done_o; ack packets go out on the return network.
module bsg_manycore_store_ack_tracker #(
    parameter int x_cord_width_p = 5,
    parameter int y_cord_width_p = 5,
    parameter int max_out_p = 32,
    parameter int ack_fifo_els_p = 2,
    localparam int ret_pack_width_lp = 5 + x_cord_width_p + y_cord_width_p,
    localparam int cnt_width_lp = $clog2(max_out_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         out_store_v_i,
    input  logic                         out_store_ready_i,
    output logic                         credit_avail_o,
    input  logic                         in_store_v_i,
    input  logic [x_cord_width_p-1:0]    in_src_x_i,
    input  logic [y_cord_width_p-1:0]    in_src_y_i,
    output logic                         in_store_ready_o,
    output logic                         ret_v_o,
    output logic [ret_pack_width_lp-1:0] ret_data_o,
    input  logic                         ret_ready_i,
    input  logic                         ret_v_i,
    input  logic [ret_pack_width_lp-1:0] ret_data_i,
    output logic                         ret_ready_o,
    output logic [cnt_width_lp-1:0]      outstanding_o,
    output logic                         stores_done_o,
    output logic                         underflow_o
);

    localparam int op_bit_lp = x_cord_width_p + y_cord_width_p;
    localparam int ptr_width_lp =
        (ack_fifo_els_p > 1) ? $clog2(ack_fifo_els_p) : 1;
    localparam int num_width_lp = $clog2(ack_fifo_els_p + 1);
    localparam logic [cnt_width_lp-1:0] max_cnt_lp =
        cnt_width_lp'(max_out_p);
    localparam logic [num_width_lp-1:0] full_num_lp =
        num_width_lp'(ack_fifo_els_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp =
        ptr_width_lp'(ack_fifo_els_p - 1);

    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    underflow_q, underflow_d;
    logic                    inc, dec;

    // Only the op bit of an arriving return packet matters.
    logic unused_ret_data;
    assign unused_ret_data = ^ret_data_i;

    assign ret_ready_o = ~reset_i;
    assign inc = out_store_v_i & out_store_ready_i;
    assign dec = ret_v_i & ret_ready_o & ret_data_i[op_bit_lp];

    always_comb begin
        cnt_d = cnt_q;
        underflow_d = underflow_q;
        if (inc & ~dec) begin
            if (cnt_q != max_cnt_lp) begin
                cnt_d = cnt_q + cnt_width_lp'(1);
            end
        end else if (dec & ~inc) begin
            if (cnt_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                cnt_d = cnt_q - cnt_width_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign stores_done_o = (cnt_q == '0);
    assign credit_avail_o = (cnt_q != max_cnt_lp);
    assign underflow_o = underflow_q;

    logic [ret_pack_width_lp-1:0] mem_q [ack_fifo_els_p];
    logic [ptr_width_lp-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]      rd_ptr_q, rd_ptr_d;
    logic [num_width_lp-1:0]      num_q, num_d;
    logic [ret_pack_width_lp-1:0] pkt;
    logic                         enq, deq;

    function automatic logic [ptr_width_lp-1:0] next_ptr(
        input logic [ptr_width_lp-1:0] p
    );
        if (p == last_ptr_lp) begin
            return '0;
        end
        return p + ptr_width_lp'(1);
    endfunction

    assign pkt = {4'b0000, 1'b1, in_src_y_i, in_src_x_i};

    // Ready depends on registered occupancy only, never on ret_ready_i.
    assign in_store_ready_o = (num_q != full_num_lp);
    assign ret_v_o = (num_q != '0);
    assign ret_data_o = mem_q[rd_ptr_q];
    assign enq = in_store_v_i & in_store_ready_o;
    assign deq = ret_v_o & ret_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        num_d = num_q;
        if (enq) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (deq) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (enq & ~deq) begin
            num_d = num_q + num_width_lp'(1);
        end else if (deq & ~enq) begin
            num_d = num_q - num_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            num_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            num_q <= num_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= pkt;
        end
    end

endmodule

// File: tb/tb_bsg_manycore_store_ack_tracker.sv
// Bench for the store-ack tracker: queue/integer reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bsg_manycore_store_ack_tracker;

    localparam int XW = 5;
    localparam int YW = 5;
    localparam int MAXO = 32;
    localparam int ELS = 2;
    localparam int PW = 5 + XW + YW;
    localparam int CW = $clog2(MAXO + 1);

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic out_store_v_i = 1'b0;
    logic out_store_ready_i = 1'b0;
    logic credit_avail_o;
    logic in_store_v_i = 1'b0;
    logic [XW-1:0] in_src_x_i = '0;
    logic [YW-1:0] in_src_y_i = '0;
    logic in_store_ready_o;
    logic ret_v_o;
    logic [PW-1:0] ret_data_o;
    logic ret_ready_i = 1'b0;
    logic ret_v_i = 1'b0;
    logic [PW-1:0] ret_data_i = '0;
    logic ret_ready_o;
    logic [CW-1:0] outstanding_o;
    logic stores_done_o;
    logic underflow_o;

    bsg_manycore_store_ack_tracker #(
        .x_cord_width_p(XW),
        .y_cord_width_p(YW),
        .max_out_p(MAXO),
        .ack_fifo_els_p(ELS)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .out_store_v_i(out_store_v_i),
        .out_store_ready_i(out_store_ready_i),
        .credit_avail_o(credit_avail_o),
        .in_store_v_i(in_store_v_i),
        .in_src_x_i(in_src_x_i),
        .in_src_y_i(in_src_y_i),
        .in_store_ready_o(in_store_ready_o),
        .ret_v_o(ret_v_o),
        .ret_data_o(ret_data_o),
        .ret_ready_i(ret_ready_i),
        .ret_v_i(ret_v_i),
        .ret_data_i(ret_data_i),
        .ret_ready_o(ret_ready_o),
        .outstanding_o(outstanding_o),
        .stores_done_o(stores_done_o),
        .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_cnt = 0;
    bit m_uf = 1'b0;
    logic [PW-1:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Compare, then advance the model with the inputs the next edge samples.
    always @(negedge clk) begin
        bit inc, dec, enq, deq;
        chk("m_outstanding", 32'(outstanding_o), 32'(m_cnt));
        chk("m_done", 32'(stores_done_o), 32'(m_cnt == 0));
        chk("m_credit", 32'(credit_avail_o), 32'(m_cnt != MAXO));
        chk("m_underflow", 32'(underflow_o), 32'(m_uf));
        chk("m_in_ready", 32'(in_store_ready_o), 32'(m_q.size() < ELS));
        chk("m_ret_v", 32'(ret_v_o), 32'(m_q.size() > 0));
        chk("m_ret_ready", 32'(ret_ready_o), 32'(!reset_i));
        if (m_q.size() > 0) begin
            chk("m_ret_data", 32'(ret_data_o), 32'(m_q[0]));
        end
        if (reset_i) begin
            m_cnt = 0;
            m_uf = 1'b0;
            m_q.delete();
        end else begin
            inc = out_store_v_i && out_store_ready_i;
            dec = ret_v_i && ret_data_i[XW+YW];
            enq = in_store_v_i && (m_q.size() < ELS);
            deq = ret_ready_i && (m_q.size() > 0);
            if (inc && !dec) begin
                if (m_cnt < MAXO) m_cnt = m_cnt + 1;
            end else if (dec && !inc) begin
                if (m_cnt == 0) m_uf = 1'b1;
                else m_cnt = m_cnt - 1;
            end
            if (deq) void'(m_q.pop_front());
            if (enq) m_q.push_back({4'b0000, 1'b1, in_src_y_i, in_src_x_i});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stores(input int n);
        out_store_v_i = 1'b1;
        out_store_ready_i = 1'b1;
        repeat (n) tick();
        out_store_v_i = 1'b0;
        out_store_ready_i = 1'b0;
    endtask

    task automatic acks(input int n);
        ret_v_i = 1'b1;
        ret_data_i = PW'(15'h0400);
        repeat (n) tick();
        ret_v_i = 1'b0;
        ret_data_i = '0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ret_ready", 32'(ret_ready_o), 32'h0);
        reset_i = 1'b0;
        tick();
        chk("rst_cnt", 32'(outstanding_o), 32'h0);
        chk("rst_done", 32'(stores_done_o), 32'h1);
        chk("rst_credit", 32'(credit_avail_o), 32'h1);
        chk("rst_in_ready", 32'(in_store_ready_o), 32'h1);
        chk("rst_ret_v", 32'(ret_v_o), 32'h0);
        chk("rst_ret_ready1", 32'(ret_ready_o), 32'h1);

        stores(3);
        chk("t1_cnt3", 32'(outstanding_o), 32'd3);
        chk("t1_done0", 32'(stores_done_o), 32'h0);
        ret_v_i = 1'b1;
        ret_data_i = '0;
        tick();
        ret_v_i = 1'b0;
        chk("t1_op0_drop", 32'(outstanding_o), 32'd3);
        acks(3);
        chk("t1_cnt0", 32'(outstanding_o), 32'd0);
        chk("t1_done1", 32'(stores_done_o), 32'h1);

        stores(32);
        chk("t2_cnt32", 32'(outstanding_o), 32'd32);
        chk("t2_credit0", 32'(credit_avail_o), 32'h0);
        stores(1);
        chk("t2_sat", 32'(outstanding_o), 32'd32);
        acks(1);
        chk("t2_cnt31", 32'(outstanding_o), 32'd31);
        chk("t2_credit1", 32'(credit_avail_o), 32'h1);
        acks(26);
        chk("t3_cnt5", 32'(outstanding_o), 32'd5);
        out_store_v_i = 1'b1;
        out_store_ready_i = 1'b1;
        acks(1);
        chk("t3_both5", 32'(outstanding_o), 32'd5);
        out_store_v_i = 1'b0;
        out_store_ready_i = 1'b0;
        acks(5);
        out_store_v_i = 1'b1;
        out_store_ready_i = 1'b1;
        acks(1);
        out_store_v_i = 1'b0;
        out_store_ready_i = 1'b0;
        chk("t3_both0", 32'(outstanding_o), 32'd0);
        chk("t3_no_uf", 32'(underflow_o), 32'h0);

        acks(1);
        chk("t4_uf", 32'(underflow_o), 32'h1);
        chk("t4_cnt0", 32'(outstanding_o), 32'd0);
        tick();
        chk("t4_sticky", 32'(underflow_o), 32'h1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t4_cleared", 32'(underflow_o), 32'h0);

        ret_ready_i = 1'b0;
        in_store_v_i = 1'b1;
        in_src_x_i = 5'd2;
        in_src_y_i = 5'd1;
        tick();
        chk("t5_v1", 32'(ret_v_o), 32'h1);
        chk("t5_d1", 32'(ret_data_o), 32'h0422);
        in_src_x_i = 5'd4;
        in_src_y_i = 5'd3;
        tick();
        chk("t5_full", 32'(in_store_ready_o), 32'h0);
        chk("t5_hold", 32'(ret_data_o), 32'h0422);
        in_src_x_i = 5'd6;
        in_src_y_i = 5'd5;
        tick();
        chk("t5_hold2", 32'(ret_data_o), 32'h0422);
        in_store_v_i = 1'b0;
        ret_ready_i = 1'b1;
        tick();
        chk("t5_second", 32'(ret_data_o), 32'h0464);
        chk("t5_v2", 32'(ret_v_o), 32'h1);
        tick();
        chk("t5_empty", 32'(ret_v_o), 32'h0);

        ret_ready_i = 1'b0;
        in_store_v_i = 1'b1;
        in_src_x_i = 5'd1;
        in_src_y_i = 5'd1;
        out_store_v_i = 1'b1;
        out_store_ready_i = 1'b1;
        repeat (2) tick();
        in_store_v_i = 1'b0;
        stores(5);
        chk("t6_cnt7", 32'(outstanding_o), 32'd7);
        chk("t6_v", 32'(ret_v_o), 32'h1);
        reset_i = 1'b1;
        tick();
        chk("t6_rst_v", 32'(ret_v_o), 32'h0);
        chk("t6_rst_cnt", 32'(outstanding_o), 32'd0);
        reset_i = 1'b0;
        tick();

        for (int i = 0; i < 400; i++) begin
            out_store_v_i = 1'($urandom_range(0, 1));
            out_store_ready_i = ($urandom_range(0, 3) != 0);
            ret_v_i = ($urandom_range(0, 2) == 0);
            ret_data_i = PW'($urandom);
            in_store_v_i = 1'($urandom_range(0, 1));
            in_src_x_i = XW'($urandom);
            in_src_y_i = YW'($urandom);
            ret_ready_i = 1'($urandom_range(0, 1));
            reset_i = ($urandom_range(0, 79) == 0);
            tick();
        end
        out_store_v_i = 1'b0;
        ret_v_i = 1'b0;
        in_store_v_i = 1'b0;
        reset_i = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
